// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// MEM/WB pipeline register and writeback logic for the 5-stage MIPS core.
// It captures the results that leave the memory stage and formats load data
// (byte/half, signed/unsigned). It then picks the ALU, load or link value for
// writeback and drives the register file write port. It also keeps a count of
// retired instructions.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   When it is defined, misaligned LW/LH/LHU loads in WB suppress the
//   register write and set a sticky misalign_err flag.
//   When it is not defined, misalign_err is tied to 0, LW ignores addr_lo,
//   and LH/LHU use addr_lo[1] only.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   stall          hold the WB register contents
//   flush          load a bubble into the WB register (flush beats stall)
//   mem_valid      MEM stage holds a real instruction
//   mem_reg_write  instruction writes a GPR
//   mem_wb_sel     00 ALU, 01 load, 10 link, 11 ALU
//   mem_load_type  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, others LW
//   mem_addr_lo    effective address bits [1:0]
//   mem_alu_result ALU result
//   mem_read_data  raw aligned word from data memory
//   mem_link_data  link address for JAL/JALR
//   mem_write_reg  destination register
//   RegWrite       register file write enable
//   WriteReg       register file write address
//   WriteData      register file write data
//   wb_valid       WB register holds a valid instruction
//   retire_count   instructions retired (wraps)
//   misalign_err   sticky misaligned-load flag
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [1:0]        mem_wb_sel,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] mem_link_data,
  input  logic [4:0]        mem_write_reg,
  output logic              RegWrite,
  output logic [4:0]        WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retire_count,
  output logic              misalign_err
);

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  logic              wb_reg_write;
  logic [1:0]        wb_sel;
  logic [2:0]        wb_load_type;
  logic [1:0]        wb_addr_lo;
  logic [DATA_W-1:0] wb_alu_result;
  logic [DATA_W-1:0] wb_read_data;
  logic [DATA_W-1:0] wb_link_data;
  logic [4:0]        wb_write_reg;

  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [DATA_W-1:0] load_value;
  logic              misaligned;

  // The raw memory word is stored, and formatting happens on the register
  // side, so no mem_* input reaches an output combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_sel        <= 2'b00;
      wb_load_type  <= 3'b000;
      wb_addr_lo    <= 2'b00;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_link_data  <= '0;
      wb_write_reg  <= 5'd0;
    end else if (flush) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_sel        <= 2'b00;
      wb_load_type  <= 3'b000;
      wb_addr_lo    <= 2'b00;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_link_data  <= '0;
      wb_write_reg  <= 5'd0;
    end else if (!stall) begin
      wb_valid      <= mem_valid;
      wb_reg_write  <= mem_reg_write;
      wb_sel        <= mem_wb_sel;
      wb_load_type  <= mem_load_type;
      wb_addr_lo    <= mem_addr_lo;
      wb_alu_result <= mem_alu_result;
      wb_read_data  <= mem_read_data;
      wb_link_data  <= mem_link_data;
      wb_write_reg  <= mem_write_reg;
    end
  end

  // An instruction retires when it leaves WB, which is any edge that neither
  // holds it (stall) nor kills it (flush).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_count <= '0;
    end else if (wb_valid && !stall && !flush) begin
      retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Little-endian lane selection: the byte lane comes from addr_lo and the
  // halfword lane comes from addr_lo[1].
  always_comb begin
    load_byte = wb_read_data[7:0];
    case (wb_addr_lo)
      2'd0: load_byte = wb_read_data[7:0];
      2'd1: load_byte = wb_read_data[15:8];
      2'd2: load_byte = wb_read_data[23:16];
      2'd3: load_byte = wb_read_data[31:24];
      default: load_byte = wb_read_data[7:0];
    endcase
    load_half = wb_addr_lo[1] ? wb_read_data[31:16] : wb_read_data[15:0];
  end

  always_comb begin
    load_value = wb_read_data;
    case (wb_load_type)
      LT_LB:   load_value = {{(DATA_W-8){load_byte[7]}}, load_byte};
      LT_LBU:  load_value = {{(DATA_W-8){1'b0}}, load_byte};
      LT_LH:   load_value = {{(DATA_W-16){load_half[15]}}, load_half};
      LT_LHU:  load_value = {{(DATA_W-16){1'b0}}, load_half};
      default: load_value = wb_read_data;
    endcase
  end

  always_comb begin
    WriteData = wb_alu_result;
    case (wb_sel)
      SEL_LOAD: WriteData = load_value;
      SEL_LINK: WriteData = wb_link_data;
      default:  WriteData = wb_alu_result;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  // Types that are not a byte or halfword load behave as LW and need word
  // alignment. Halfwords only need bit 0 clear.
  always_comb begin
    misaligned = 1'b0;
    if (wb_valid && wb_sel == SEL_LOAD) begin
      case (wb_load_type)
        LT_LB, LT_LBU: misaligned = 1'b0;
        LT_LH, LT_LHU: misaligned = wb_addr_lo[0];
        default:       misaligned = (wb_addr_lo != 2'b00);
      endcase
    end
  end

  // The flag is sticky until reset. It records whichever misaligned load sat
  // in WB at an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_err <= 1'b0;
    end else if (misaligned) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign WriteReg = wb_write_reg;
  assign RegWrite = wb_valid && wb_reg_write && (wb_write_reg != 5'd0) && !misaligned;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
// Scoreboard bench for mem_wb_stage. The driver applies one stimulus per
// cycle, advances a behavioural model and queues the expected WB outputs.
// A monitor then compares the DUT against the queue after every rising edge.
// The DUT uses a 4-bit retire counter so that wrap-around is exercised.
module tb_mem_wb_stage;

  localparam int CNT_W = 4;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        stall;
    logic        flush;
    logic        valid;
    logic        rw;
    logic [1:0]  sel;
    logic [2:0]  lt;
    logic [1:0]  lo;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] link;
    logic [4:0]  wr;
  } stim_t;

  typedef struct {
    logic             valid;
    logic             rw;
    logic [4:0]       wreg;
    logic [31:0]      wdata;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             mem_valid = 1'b0;
  logic             mem_reg_write = 1'b0;
  logic [1:0]       mem_wb_sel = 2'b00;
  logic [2:0]       mem_load_type = 3'b000;
  logic [1:0]       mem_addr_lo = 2'b00;
  logic [31:0]      mem_alu_result = 32'd0;
  logic [31:0]      mem_read_data = 32'd0;
  logic [31:0]      mem_link_data = 32'd0;
  logic [4:0]       mem_write_reg = 5'd0;
  logic             RegWrite;
  logic [4:0]       WriteReg;
  logic [31:0]      WriteData;
  logic             wb_valid;
  logic [CNT_W-1:0] retire_count;
  logic             misalign_err;

  int checks = 0;
  int failures = 0;

  exp_t  sbQ[$];
  stim_t m;
  int    mCnt;
  bit    mErr;

  mem_wb_stage #(.DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .stall(stall),
    .flush(flush),
    .mem_valid(mem_valid),
    .mem_reg_write(mem_reg_write),
    .mem_wb_sel(mem_wb_sel),
    .mem_load_type(mem_load_type),
    .mem_addr_lo(mem_addr_lo),
    .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data),
    .mem_link_data(mem_link_data),
    .mem_write_reg(mem_write_reg),
    .RegWrite(RegWrite),
    .WriteReg(WriteReg),
    .WriteData(WriteData),
    .wb_valid(wb_valid),
    .retire_count(retire_count),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic stim_t blank();
    stim_t s;
    s.stall = 0; s.flush = 0; s.valid = 0; s.rw = 0; s.sel = 0; s.lt = 0;
    s.lo = 0; s.alu = 0; s.rd = 0; s.link = 0; s.wr = 0;
    return s;
  endfunction

  // Load result from the architectural rules: pick the lane with shifts and
  // masks, and sign-extend by subtracting 2^8 or 2^16 when the top bit is set.
  function automatic logic [31:0] loadValue(logic [2:0] lt, logic [1:0] lo, logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * lo)) & 32'hFF;
    h = lo[1] ? (rd >> 16) : (rd & 32'hFFFF);
    case (lt)
      3'd3:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd2:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic bit isMisaligned(stim_t s);
    if (!TRAP || !s.valid || s.sel != 2'b01) return 0;
    if (s.lt == 3'd3 || s.lt == 3'd4) return 0;
    if (s.lt == 3'd1 || s.lt == 3'd2) return s.lo[0];
    return s.lo != 2'b00;
  endfunction

  function automatic exp_t expected(stim_t s, int cnt, bit err);
    exp_t e;
    e.valid = s.valid;
    e.rw    = s.valid && s.rw && (s.wr != 0) && !isMisaligned(s);
    e.wreg  = s.wr;
    e.wdata = (s.sel == 2'b10) ? s.link : (s.sel == 2'b01) ? loadValue(s.lt, s.lo, s.rd) : s.alu;
    e.cnt   = CNT_W'(cnt);
    e.err   = err;
    return e;
  endfunction

  task automatic modelReset();
    m    = blank();
    mCnt = 0;
    mErr = 0;
  endtask

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] want);
    checks++;
    if (actual !== want) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, want, $time);
    end
  endtask

  // Called at a negedge. It drives one cycle of inputs, advances the model
  // over the next rising edge and queues the result for the monitor.
  task automatic applyStimulus(stim_t s);
    stall = s.stall; flush = s.flush; mem_valid = s.valid; mem_reg_write = s.rw;
    mem_wb_sel = s.sel; mem_load_type = s.lt; mem_addr_lo = s.lo;
    mem_alu_result = s.alu; mem_read_data = s.rd; mem_link_data = s.link;
    mem_write_reg = s.wr;
    if (m.valid && !s.stall && !s.flush) mCnt = (mCnt + 1) % (1 << CNT_W);
    if (isMisaligned(m)) mErr = 1;
    if (s.flush) m = blank();
    else if (!s.stall) m = s;
    sbQ.push_back(expected(m, mCnt, mErr));
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic stim_t op(logic [1:0] sel, logic [2:0] lt, logic [1:0] lo, logic [31:0] alu,
                               logic [31:0] rd, logic [31:0] link, logic [4:0] wr);
    stim_t s = blank();
    s.valid = 1; s.rw = 1; s.sel = sel; s.lt = lt; s.lo = lo;
    s.alu = alu; s.rd = rd; s.link = link; s.wr = wr;
    return s;
  endfunction

  // The monitor is independent of the driver and pops one expectation for
  // every edge that has one.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("wb_valid", 32'(wb_valid), 32'(e.valid));
        checkOutput("RegWrite", 32'(RegWrite), 32'(e.rw));
        checkOutput("WriteReg", 32'(WriteReg), 32'(e.wreg));
        checkOutput("WriteData", WriteData, e.wdata);
        checkOutput("retire_count", 32'(retire_count), 32'(e.cnt));
        checkOutput("misalign_err", 32'(misalign_err), 32'(e.err));
      end
    end
  end

  initial begin
    stim_t s;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset_RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("reset_WriteData", WriteData, 32'd0);
    checkOutput("reset_retire_count", 32'(retire_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ALU write, followed by the load lane formatting cases.
    applyStimulus(op(2'b00, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 5'd8));
    applyStimulus(op(2'b01, 3'd3, 2'd0, 32'h0, 32'h80FF_7F01, 32'h0, 5'd9));
    applyStimulus(op(2'b01, 3'd3, 2'd2, 32'h0, 32'h80FF_7F01, 32'h0, 5'd10));
    applyStimulus(op(2'b01, 3'd4, 2'd3, 32'h0, 32'h80FF_7F01, 32'h0, 5'd11));
    applyStimulus(op(2'b01, 3'd1, 2'd2, 32'h0, 32'h80FF_7F01, 32'h0, 5'd12));
    applyStimulus(op(2'b01, 3'd2, 2'd0, 32'h0, 32'h80FF_7F01, 32'h0, 5'd13));
    // Register 0 is never written, but the instruction still retires.
    applyStimulus(op(2'b00, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0));
    // Link writeback.
    applyStimulus(op(2'b10, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0040_0008, 5'd31));
    // Stall for three cycles while the inputs change underneath.
    for (int i = 0; i < 3; i++) begin
      s = op(2'b00, 3'd0, 2'd0, 32'h5555_0000 + 32'(i), 32'h0, 32'h0, 5'd3);
      s.stall = 1;
      applyStimulus(s);
    end
    // Stall and flush together, so the flush wins.
    s = op(2'b00, 3'd0, 2'd0, 32'h7777_7777, 32'h0, 32'h0, 5'd4);
    s.stall = 1; s.flush = 1;
    applyStimulus(s);
    // Misaligned LW: it traps only when MISALIGN_TRAP_EN is defined.
    applyStimulus(op(2'b01, 3'd0, 2'd2, 32'h0, 32'hCAFE_F00D, 32'h0, 5'd5));
    applyStimulus(op(2'b00, 3'd0, 2'd0, 32'h1111_2222, 32'h0, 32'h0, 5'd6));
    applyStimulus(op(2'b00, 3'd0, 2'd0, 32'h3333_4444, 32'h0, 32'h0, 5'd7));
    // Sixteen back-to-back retirements, which wrap the 4-bit counter.
    for (int i = 0; i < 16; i++)
      applyStimulus(op(2'b00, 3'd0, 2'd0, 32'(i), 32'h0, 32'h0, 5'd1));

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      s = blank();
      s.stall = ($urandom_range(0, 9) < 2);
      s.flush = ($urandom_range(0, 9) == 0);
      s.valid = ($urandom_range(0, 9) < 8);
      s.rw    = ($urandom_range(0, 9) < 8);
      s.sel   = 2'($urandom_range(0, 3));
      s.lt    = 3'($urandom_range(0, 7));
      s.lo    = 2'($urandom_range(0, 3));
      s.alu   = $urandom;
      s.rd    = $urandom;
      s.link  = $urandom;
      s.wr    = 5'($urandom_range(0, 31));
      applyStimulus(s);
    end

    // Assert reset asynchronously in the middle of a stalled cycle.
    s = op(2'b00, 3'd0, 2'd0, 32'hABCD_0123, 32'h0, 32'h0, 5'd20);
    applyStimulus(s);
    s.stall = 1;
    stall = 1'b1;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("async_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("async_RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("async_WriteReg", 32'(WriteReg), 32'd0);
    checkOutput("async_WriteData", WriteData, 32'd0);
    checkOutput("async_retire_count", 32'(retire_count), 32'd0);
    checkOutput("async_misalign_err", 32'(misalign_err), 32'd0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    stall = 1'b0;
    applyStimulus(op(2'b00, 3'd0, 2'd0, 32'h0BAD_F00D, 32'h0, 32'h0, 5'd2));
    applyStimulus(blank());

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
